framebuffer_scanout: RTL and testbench

Read-side consumer of the pixel framebuffer. Generates raster timing for a fixed video mode and issues one framebuffer read address per visible pixel. It absorbs the framebuffer's 1-clock registered read latency and emits the pixel aligned with hsync, vsync and data-enable to the video output stage. One pixel per clock; i_Clock is the pixel clock, and the framebuffer read port shares it.

---
 rtl/framebuffer_scanout_pkg.sv | 27 ++
 rtl/video_timing_generator.sv | 64 ++++++
 rtl/framebuffer_scanout.sv | 85 ++++++++
 tb/tb_framebuffer_scanout.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/framebuffer_scanout_pkg.sv
// Shared raster timing defaults (640x480@60) and types for the framebuffer scanout path.
package framebuffer_scanout_pkg;

    localparam int VT_H_VISIBLE = 640;
    localparam int VT_H_FRONT   = 16;
    localparam int VT_H_SYNC    = 96;
    localparam int VT_H_BACK    = 48;
    localparam int VT_V_VISIBLE = 480;
    localparam int VT_V_FRONT   = 10;
    localparam int VT_V_SYNC    = 2;
    localparam int VT_V_BACK    = 33;
    localparam int VT_H_TOTAL   = VT_H_VISIBLE + VT_H_FRONT + VT_H_SYNC + VT_H_BACK;
    localparam int VT_V_TOTAL   = VT_V_VISIBLE + VT_V_FRONT + VT_V_SYNC + VT_V_BACK;

    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
        logic frame_start;
    } raster_flags_t;

    // Maps a logical "sync asserted" flag onto the pin level for the chosen polarity.
    function automatic logic sync_level(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/video_timing_generator.sv
// Stage-0 raster counters: H/V position plus raw visible/sync/frame-start flags.
module video_timing_generator
    import framebuffer_scanout_pkg::*;
#(
    parameter int H_VISIBLE = VT_H_VISIBLE,
    parameter int H_FRONT   = VT_H_FRONT,
    parameter int H_SYNC    = VT_H_SYNC,
    parameter int H_BACK    = VT_H_BACK,
    parameter int V_VISIBLE = VT_V_VISIBLE,
    parameter int V_FRONT   = VT_V_FRONT,
    parameter int V_SYNC    = VT_V_SYNC,
    parameter int V_BACK    = VT_V_BACK
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    output raster_flags_t o_Flags,
    output logic          o_Frame_End,
    output logic          o_Last_Visible
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // One spare bit so sync-end constants equal to the total still fit.
    localparam int H_W = $clog2(H_TOTAL + 1);
    localparam int V_W = $clog2(V_TOTAL + 1);

    localparam logic [H_W-1:0] H_LAST       = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS_END    = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0] H_VIS_LAST   = H_W'(H_VISIBLE - 1);
    localparam logic [H_W-1:0] H_SYNC_START = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0] H_SYNC_END   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] V_LAST       = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS_END    = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0] V_VIS_LAST   = V_W'(V_VISIBLE - 1);
    localparam logic [V_W-1:0] V_SYNC_START = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0] V_SYNC_END   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [H_W-1:0] r_H_Count;
    logic [V_W-1:0] r_V_Count;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_H_Count <= '0;
            r_V_Count <= '0;
        end else if (r_H_Count == H_LAST) begin
            r_H_Count <= '0;
            r_V_Count <= (r_V_Count == V_LAST) ? '0 : r_V_Count + 1'b1;
        end else begin
            r_H_Count <= r_H_Count + 1'b1;
        end
    end

    always_comb begin
        o_Flags             = '0;
        o_Flags.visible     = (r_H_Count < H_VIS_END) && (r_V_Count < V_VIS_END);
        o_Flags.hsync       = (r_H_Count >= H_SYNC_START) && (r_H_Count < H_SYNC_END);
        o_Flags.vsync       = (r_V_Count >= V_SYNC_START) && (r_V_Count < V_SYNC_END);
        o_Flags.frame_start = (r_H_Count == '0) && (r_V_Count == '0);
    end

    assign o_Frame_End    = (r_H_Count == H_LAST) && (r_V_Count == V_LAST);
    assign o_Last_Visible = (r_H_Count == H_VIS_LAST) && (r_V_Count == V_VIS_LAST);

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer read-side scanout: address generation and 2-clock alignment of pixel with syncs/DE.
module framebuffer_scanout
    import framebuffer_scanout_pkg::*;
#(
    parameter int BITS_PER_PIXEL  = 4,
    parameter int H_VISIBLE       = VT_H_VISIBLE,
    parameter int H_FRONT         = VT_H_FRONT,
    parameter int H_SYNC          = VT_H_SYNC,
    parameter int H_BACK          = VT_H_BACK,
    parameter int V_VISIBLE       = VT_V_VISIBLE,
    parameter int V_FRONT         = VT_V_FRONT,
    parameter int V_SYNC          = VT_V_SYNC,
    parameter int V_BACK          = VT_V_BACK,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    output logic [31:0]               o_Read_Addr,
    input  logic [BITS_PER_PIXEL-1:0] i_Read_Data,
    output logic [BITS_PER_PIXEL-1:0] o_Pixel,
    output logic                      o_Hsync,
    output logic                      o_Vsync,
    output logic                      o_Data_Enable,
    output logic                      o_Frame_Start
);

    localparam logic SYNC_LOW = (SYNC_ACTIVE_LOW != 0);

    raster_flags_t w_Raw;
    raster_flags_t r_Stage1;
    logic          w_Frame_End;
    logic          w_Last_Visible;
    logic [31:0]   r_Read_Addr;

    video_timing_generator #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .o_Flags        (w_Raw),
        .o_Frame_End    (w_Frame_End),
        .o_Last_Visible (w_Last_Visible)
    );

    // The last visible pixel does not advance, so the address tops out at
    // H_VISIBLE*V_VISIBLE-1 and holds there through vertical blanking.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Read_Addr <= '0;
        end else if (w_Frame_End) begin
            r_Read_Addr <= '0;
        end else if (w_Raw.visible && !w_Last_Visible) begin
            r_Read_Addr <= r_Read_Addr + 32'd1;
        end
    end

    assign o_Read_Addr = r_Read_Addr;

    // Stage 1 runs alongside the framebuffer's registered read; stage 2 is the output register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Stage1      <= '0;
            o_Pixel       <= '0;
            o_Hsync       <= SYNC_LOW;
            o_Vsync       <= SYNC_LOW;
            o_Data_Enable <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            r_Stage1      <= w_Raw;
            o_Pixel       <= r_Stage1.visible ? i_Read_Data : '0;
            o_Hsync       <= sync_level(r_Stage1.hsync, SYNC_LOW);
            o_Vsync       <= sync_level(r_Stage1.vsync, SYNC_LOW);
            o_Data_Enable <= r_Stage1.visible;
            o_Frame_Start <= r_Stage1.frame_start;
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout in a small 8x4 raster (12x8 totals, 96 clocks/frame).
module tb_framebuffer_scanout;

    localparam int BPP = 4;
    localparam int HV = 8, HF = 1, HS = 2, HB = 1;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    typedef struct {
        logic           de;
        logic [BPP-1:0] pix;
        logic           hs;
        logic           vs;
        logic           fs;
    } rec_t;

    logic           i_Clock = 1'b0;
    logic           i_Reset = 1'b1;
    logic [31:0]    o_Read_Addr;
    logic [BPP-1:0] i_Read_Data;
    logic [BPP-1:0] o_Pixel;
    logic           o_Hsync, o_Vsync, o_Data_Enable, o_Frame_Start;

    logic fb_force = 1'b0;
    int   checks = 0;
    int   errors = 0;
    rec_t sb[$];
    int   mh, mv, cyc, last_fs_cyc, de_run;

    framebuffer_scanout #(
        .BITS_PER_PIXEL (BPP),
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .SYNC_ACTIVE_LOW (1)
    ) dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .o_Read_Addr   (o_Read_Addr),
        .i_Read_Data   (i_Read_Data),
        .o_Pixel       (o_Pixel),
        .o_Hsync       (o_Hsync),
        .o_Vsync       (o_Vsync),
        .o_Data_Enable (o_Data_Enable),
        .o_Frame_Start (o_Frame_Start)
    );

    always #5 i_Clock = ~i_Clock;

    // Behavioural framebuffer: one-clock registered read, data = low nibble of the address.
    always @(posedge i_Clock) i_Read_Data <= fb_force ? 4'hF : o_Read_Addr[3:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int h, input int v);
        if (v >= VV) return HV * VV - 1;
        if (v == VV - 1) return v * HV + ((h < HV) ? h : HV - 1);
        return v * HV + ((h < HV) ? h : HV);
    endfunction

    function automatic rec_t make_rec(input int h, input int v, input logic force_f);
        rec_t r;
        logic [31:0] a;
        a    = exp_addr(h, v);
        r.de = (h < HV) && (v < VV);
        r.pix = r.de ? (force_f ? 4'hF : a[3:0]) : 4'h0;
        r.hs = !((h >= HV + HF) && (h < HV + HF + HS));
        r.vs = !((v >= VV + VF) && (v < VV + VF + VS));
        r.fs = (h == 0) && (v == 0);
        return r;
    endfunction

    task automatic model_restart();
        sb.delete();
        mh = 0;
        mv = 0;
        cyc = 0;
        last_fs_cyc = -1;
        de_run = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_de"},  32'(o_Data_Enable), 32'd0);
        check({tag, "_pix"}, 32'(o_Pixel), 32'd0);
        check({tag, "_hs"},  32'(o_Hsync), 32'd1);
        check({tag, "_vs"},  32'(o_Vsync), 32'd1);
        check({tag, "_fs"},  32'(o_Frame_Start), 32'd0);
    endtask

    // Called at a falling edge; each iteration samples, scores, then waits one clock.
    task automatic run_cycles(input int n);
        rec_t e;
        for (int i = 0; i < n; i++) begin
            check("addr", o_Read_Addr, 32'(exp_addr(mh, mv)));
            sb.push_back(make_rec(mh, mv, fb_force));
            if (sb.size() > 2) begin
                e = sb.pop_front();
                check("de",    32'(o_Data_Enable), 32'(e.de));
                check("pixel", 32'(o_Pixel), 32'(e.pix));
                check("hsync", 32'(o_Hsync), 32'(e.hs));
                check("vsync", 32'(o_Vsync), 32'(e.vs));
                check("fstart", 32'(o_Frame_Start), 32'(e.fs));
            end else begin
                check_idle("startup");
            end
            if (o_Frame_Start) begin
                if (last_fs_cyc >= 0) check("frame_period", 32'(cyc - last_fs_cyc), 32'(HT * VT));
                last_fs_cyc = cyc;
            end
            if (o_Data_Enable) begin
                de_run++;
            end else begin
                if (de_run != 0) check("de_run", 32'(de_run), 32'(HV));
                de_run = 0;
            end
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
            cyc++;
            @(negedge i_Clock);
        end
    endtask

    initial begin
        model_restart();
        repeat (3) @(negedge i_Clock);
        check("rst_addr", o_Read_Addr, 32'd0);
        check_idle("rst");

        i_Reset = 1'b0;
        run_cycles(3 * HT * VT);

        // Park mid-way through visible line 1, then hit reset asynchronously.
        run_cycles(HT + 3);
        check("pre_rst_de", 32'(o_Data_Enable), 32'd1);
        i_Reset = 1'b1;
        #1;
        check("async_addr", o_Read_Addr, 32'd0);
        check_idle("async_rst");
        repeat (2) @(negedge i_Clock);
        model_restart();
        i_Reset = 1'b0;

        fb_force = 1'b1;
        run_cycles(HT * VT + 10);
        fb_force = 1'b0;
        run_cycles(HT * VT + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
